// File: rtl/pll_ce_pkg.sv
// pll_ce_pkg
// Shared definitions for the lock-qualified clock-enable generator.
//   state_t       : 2-bit FSM state encoding (IDLE/WAIT_LOCK/SETTLE/RUN)
//   DEFAULT_DIV   : divide ratio loaded into shadow/active registers on reset
//   DEFAULT_PHASE : phase offset loaded into shadow/active registers on reset
package pll_ce_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_LOCK = 2'b01,
        SETTLE    = 2'b10,
        RUN       = 2'b11
    } state_t;

    localparam int DEFAULT_DIV   = 1;
    localparam int DEFAULT_PHASE = 0;

endpackage

// File: rtl/pll_ce_chan.sv
// pll_ce_chan
// One clock-enable channel: shadow/active divide and phase registers, the
// period counter, terminal-count detection and the deferred reload rule.
// Ports:
//   refclk    : block clock
//   rst       : synchronous reset, active-low
//   in_run    : FSM is in RUN this cycle
//   run_next  : FSM will be in RUN next cycle
//   div_load  : capture div_val/phase_val into the shadow registers
//   div_val   : divide ratio for this channel
//   phase_val : start offset for this channel
//   ce        : registered single-cycle enable pulse
module pll_ce_chan
    import pll_ce_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             in_run,
    input  logic             run_next,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    input  logic [DIV_W-1:0] phase_val,
    output logic             ce
);

    logic [DIV_W-1:0] shadow_div_reg;
    logic [DIV_W-1:0] shadow_phase_reg;
    logic [DIV_W-1:0] active_div_reg;
    logic [DIV_W-1:0] active_phase_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_next;
    logic             pend_reg;
    logic             ce_reg;
    logic             ce_next;
    logic             apply;
    logic [DIV_W-1:0] div_use;
    logic [DIV_W-1:0] phase_use;
    logic             div_le1;

    always_comb begin
        // ce_reg high in RUN marks the terminal-count cycle, the only point
        // where a pending reload may take effect without cutting a period.
        apply     = pend_reg && (!in_run || ce_reg);
        div_use   = apply ? shadow_div_reg   : active_div_reg;
        phase_use = apply ? shadow_phase_reg : active_phase_reg;
        div_le1   = (div_use <= DIV_W'(1));

        cnt_next = '0;
        if (run_next) begin
            if (!in_run) begin
                // RUN entry: apply the phase offset, out-of-range phase means 0
                cnt_next = (phase_use >= div_use) ? '0 : phase_use;
            end else if (apply || div_le1 || (cnt_reg >= div_use - DIV_W'(1))) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + DIV_W'(1);
            end
        end

        // Pulse is decided from the next count so ce comes straight from a flop
        ce_next = run_next && (div_le1 || (cnt_next == div_use - DIV_W'(1)));
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            shadow_div_reg   <= DIV_W'(DEFAULT_DIV);
            shadow_phase_reg <= DIV_W'(DEFAULT_PHASE);
            active_div_reg   <= DIV_W'(DEFAULT_DIV);
            active_phase_reg <= DIV_W'(DEFAULT_PHASE);
            cnt_reg          <= '0;
            pend_reg         <= 1'b0;
            ce_reg           <= 1'b0;
        end else begin
            if (apply) begin
                active_div_reg   <= shadow_div_reg;
                active_phase_reg <= shadow_phase_reg;
            end
            // A load coinciding with an apply keeps the flag set so the new
            // value waits for the following terminal count.
            if (div_load) begin
                shadow_div_reg   <= div_val;
                shadow_phase_reg <= phase_val;
                pend_reg         <= 1'b1;
            end else if (apply) begin
                pend_reg <= 1'b0;
            end
            cnt_reg <= cnt_next;
            ce_reg  <= ce_next;
        end
    end

    assign ce = ce_reg;

endmodule

// File: rtl/pll_ce_gen.sv
// pll_ce_gen
// Lock-qualified multi-channel clock-enable generator running on the PLL
// output clock. Enables are held off until lock has been stable for
// SETTLE_CYC cycles and are dropped as soon as synchronised lock falls.
// Optional build macro: PLL_CE_LOCK_LOSS_CNT_EN adds a saturating counter of
// RUN -> WAIT_LOCK transitions on output lock_loss_cnt.
// Ports:
//   refclk        : block clock (PLL output clock)
//   rst           : synchronous reset, active-low
//   pll_locked    : raw PLL lock (asynchronous)
//   div_load      : one-cycle strobe capturing div_val/phase_val
//   div_val       : per-channel divide, channel i in [i*DIV_W +: DIV_W]
//   phase_val     : per-channel start offset, same packing
//   ce_out        : per-channel single-cycle enables
//   ready         : high while in RUN
//   state         : current FSM state code
//   lock_loss_cnt : (optional) lock losses seen in RUN, saturating at 255
module pll_ce_gen
    import pll_ce_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DIV_W      = 16,
    parameter int SETTLE_CYC = 1024
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic                    div_load,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH*DIV_W-1:0] phase_val,
    output logic [NUM_CH-1:0]       ce_out,
    output logic                    ready,
    output logic [1:0]              state
`ifdef PLL_CE_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]              lock_loss_cnt
`endif
);

    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

    logic                sync1_reg;
    logic                lock_s_reg;
    state_t              state_reg;
    state_t              state_next;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic [SETTLE_W-1:0] settle_cnt_next;
    logic                in_run;
    logic                run_next;

    // Two-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge refclk) begin
        if (!rst) begin
            sync1_reg  <= 1'b0;
            lock_s_reg <= 1'b0;
        end else begin
            sync1_reg  <= pll_locked;
            lock_s_reg <= sync1_reg;
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            settle_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        case (state_reg)
            IDLE: begin
                state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s_reg) begin
                    state_next      = SETTLE;
                    settle_cnt_next = '0;
                end
            end
            SETTLE: begin
                if (!lock_s_reg) begin
                    state_next      = WAIT_LOCK;
                    settle_cnt_next = '0;
                end else if (settle_cnt_reg == SETTLE_W'(SETTLE_CYC - 1)) begin
                    state_next = RUN;
                end else begin
                    settle_cnt_next = settle_cnt_reg + SETTLE_W'(1);
                end
            end
            RUN: begin
                if (!lock_s_reg) begin
                    state_next = WAIT_LOCK;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_run   = (state_reg == RUN);
    assign run_next = (state_next == RUN);
    assign ready    = in_run;
    assign state    = state_reg;

    // Channels see run_next so their registered enables drop on the same
    // edge that leaves RUN; no pulse can straddle a lock loss.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        pll_ce_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .refclk   (refclk),
            .rst      (rst),
            .in_run   (in_run),
            .run_next (run_next),
            .div_load (div_load),
            .div_val  (div_val[gi*DIV_W +: DIV_W]),
            .phase_val(phase_val[gi*DIV_W +: DIV_W]),
            .ce       (ce_out[gi])
        );
    end

`ifdef PLL_CE_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt_reg;

    always_ff @(posedge refclk) begin
        if (!rst) begin
            lock_loss_cnt_reg <= 8'd0;
        end else if (in_run && (state_next == WAIT_LOCK) && (lock_loss_cnt_reg != 8'hFF)) begin
            lock_loss_cnt_reg <= lock_loss_cnt_reg + 8'd1;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_reg;
`endif

endmodule

// File: tb/tb_pll_ce_gen.sv
// tb_pll_ce_gen
// Self-checking bench for pll_ce_gen (NUM_CH=4, DIV_W=16, SETTLE_CYC=8).
// A reference model predicts state, ready and each channel's pulse times
// from a lock-streak count and arithmetic pulse scheduling; every cycle the
// DUT is compared against it, plus directed checks on bring-up latency,
// phase handling, glitch-free reload, lock loss and mid-operation reset.
module tb_pll_ce_gen;

    localparam int NUM_CH     = 4;
    localparam int DIV_W      = 16;
    localparam int SETTLE_CYC = 8;

    logic                    refclk = 1'b0;
    logic                    rst = 1'b0;
    logic                    pll_locked = 1'b0;
    logic                    div_load = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_val = '0;
    logic [NUM_CH*DIV_W-1:0] phase_val = '0;
    logic [NUM_CH-1:0]       ce_out;
    logic                    ready;
    logic [1:0]              state;
`ifdef PLL_CE_LOCK_LOSS_CNT_EN
    logic [7:0]              lock_loss_cnt;
`endif

    always #5 refclk = ~refclk;

    pll_ce_gen #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .div_load  (div_load),
        .div_val   (div_val),
        .phase_val (phase_val),
        .ce_out    (ce_out),
        .ready     (ready),
        .state     (state)
`ifdef PLL_CE_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    int cyc = 0;
    int m_state = 0;
    int streak = 0;          // consecutive cycles the FSM has seen lock
    bit h1 = 1'b0;
    bit h2 = 1'b0;
    int sh_d [NUM_CH];
    int sh_p [NUM_CH];
    int ac_d [NUM_CH];
    int ac_p [NUM_CH];
    bit pend [NUM_CH];
    int next_pulse [NUM_CH];
    bit exp_ce [NUM_CH];
    int m_llc = 0;

    bit rec_seq = 1'b0;
    int seq_q[$];
    int first_ce [NUM_CH];

    int n;
    int tp;
    int e0;
    int lock_cyc;
    int q[$];
    logic [NUM_CH-1:0] ce_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit prev_ce [NUM_CH];
        int prev;
        bit ls;
        logic [NUM_CH-1:0] exp_vec;
        @(posedge refclk);
        cyc++;
        prev = m_state;
        for (int i = 0; i < NUM_CH; i++) prev_ce[i] = exp_ce[i];
        if (!rst) begin
            m_state = 0; streak = 0; h1 = 1'b0; h2 = 1'b0; m_llc = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_d[i] = 1; sh_p[i] = 0; ac_d[i] = 1; ac_p[i] = 0;
                pend[i] = 1'b0; exp_ce[i] = 1'b0; next_pulse[i] = 0;
            end
        end else begin
            // lock seen by the FSM is pll_locked from two edges back
            ls = h2; h2 = h1; h1 = pll_locked;
            if (prev == 0) begin
                m_state = 1; streak = 0;
            end else begin
                streak = ls ? streak + 1 : 0;
                if (streak == 0) m_state = 1;
                else if (streak <= SETTLE_CYC) m_state = 2;
                else m_state = 3;
            end
            if (prev == 3 && m_state == 1 && m_llc < 255) m_llc++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (pend[i] && (prev != 3 || prev_ce[i])) begin
                    ac_d[i] = sh_d[i]; ac_p[i] = sh_p[i]; pend[i] = 1'b0;
                end
                if (div_load) begin
                    sh_d[i] = int'(div_val[i*DIV_W +: DIV_W]);
                    sh_p[i] = int'(phase_val[i*DIV_W +: DIV_W]);
                    pend[i] = 1'b1;
                end
                if (m_state == 3) begin
                    if (prev != 3)
                        next_pulse[i] = (ac_d[i] <= 1) ? cyc
                                      : cyc + ac_d[i] - 1 - ((ac_p[i] >= ac_d[i]) ? 0 : ac_p[i]);
                    else if (prev_ce[i])
                        next_pulse[i] = cyc - 1 + ((ac_d[i] <= 1) ? 1 : ac_d[i]);
                    exp_ce[i] = (next_pulse[i] == cyc);
                end else begin
                    exp_ce[i] = 1'b0;
                end
            end
        end
        #1;
        for (int i = 0; i < NUM_CH; i++) exp_vec[i] = exp_ce[i];
        check("state", 32'(state), 32'(m_state));
        check("ready", 32'(ready), 32'(m_state == 3));
        check("ce_out", 32'(ce_out), 32'(exp_vec));
`ifdef PLL_CE_LOCK_LOSS_CNT_EN
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_llc));
`endif
        if (rec_seq && (seq_q.size() == 0 || seq_q[$] != int'(state))) seq_q.push_back(int'(state));
    endtask

    task automatic set_ch(input int ch, input int d, input int p);
        div_val[ch*DIV_W +: DIV_W]   = DIV_W'(d);
        phase_val[ch*DIV_W +: DIV_W] = DIV_W'(p);
    endtask

    task automatic do_load();
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int k = 0;
        while (int'(state) != s && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    // Records each channel's first pulse offset, current cycle = offset 0
    task automatic measure_first(input int cycles);
        int base = cyc;
        for (int i = 0; i < NUM_CH; i++) first_ce[i] = -1;
        for (int k = 0; k < cycles; k++) begin
            for (int i = 0; i < NUM_CH; i++)
                if (ce_out[i] && first_ce[i] < 0) first_ce[i] = cyc - base;
            tick();
        end
    endtask

    initial begin
        // Reset and bring-up with divides 1,2,3,5 phase 0
        rec_seq = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        set_ch(0, 1, 0); set_ch(1, 2, 0); set_ch(2, 3, 0); set_ch(3, 5, 0);
        do_load();
        pll_locked = 1'b1;
        lock_cyc = cyc + 1;
        ce_seen = '0;
        n = 0;
        while (state != 2'b11 && n < 40) begin
            tick();
            if (state != 2'b11) ce_seen |= ce_out;
            n++;
        end
        check("bringup_run", 32'(state), 32'(3));
        check("ready_latency", 32'(cyc - lock_cyc), 32'(2 + SETTLE_CYC));
        check("ce_before_run", 32'(ce_seen), 32'(0));
        check("seq_len", 32'(seq_q.size()), 32'(4));
        if (seq_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check("seq_code", 32'(seq_q[i]), 32'(i));
        end
        rec_seq = 1'b0;
        measure_first(12);
        check("ch0_first", 32'(first_ce[0]), 32'(0));
        check("ch1_first", 32'(first_ce[1]), 32'(1));
        check("ch2_first", 32'(first_ce[2]), 32'(2));
        check("ch3_first", 32'(first_ce[3]), 32'(4));

        // Phase 3 on ch3, applied on RUN re-entry; also lock-loss latency
        set_ch(3, 5, 3);
        do_load();
        repeat (6) tick();
        pll_locked = 1'b0;
        n = 0;
        while ((ready !== 1'b0 || ce_out !== '0) && n < 10) begin
            tick();
            n++;
        end
        check("drop_within_3", 32'(n <= 3), 32'(1));
`ifdef PLL_CE_LOCK_LOSS_CNT_EN
        check("llc_one", 32'(lock_loss_cnt), 32'(1));
`endif
        pll_locked = 1'b1;
        wait_state(3, 30, "rerun_phase3");
        measure_first(12);
        check("ch3_phase3_first", 32'(first_ce[3]), 32'(1));

        // Phase 7 >= divide 5 behaves as phase 0
        set_ch(3, 5, 7);
        do_load();
        repeat (6) tick();
        pll_locked = 1'b0;
        wait_state(1, 10, "drop_phase7");
        pll_locked = 1'b1;
        wait_state(3, 30, "rerun_phase7");
        measure_first(12);
        check("ch3_phase7_first", 32'(first_ce[3]), 32'(4));

        // Glitch-free reload of ch1 from 4 to 2 mid-period
        set_ch(1, 4, 0);
        do_load();
        repeat (8) tick();
        n = 0;
        while (!ce_out[1] && n < 10) begin
            tick();
            n++;
        end
        check("ch1_pulse_found", 32'(ce_out[1]), 32'(1));
        tp = cyc;
        tick();
        set_ch(1, 2, 0);
        do_load();
        q.delete();
        repeat (12) begin
            tick();
            if (ce_out[1]) q.push_back(cyc);
        end
        check("reload_pulse_count", 32'(q.size() >= 3), 32'(1));
        if (q.size() >= 3) begin
            check("reload_gap_old", 32'(q[0] - tp), 32'(4));
            check("reload_gap_new1", 32'(q[1] - q[0]), 32'(2));
            check("reload_gap_new2", 32'(q[2] - q[1]), 32'(2));
        end

        // One-cycle lock glitch during SETTLE restarts the settle window
        pll_locked = 1'b0;
        wait_state(1, 10, "drop_for_settle");
        pll_locked = 1'b1;
        wait_state(2, 10, "settle_again");
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        e0 = cyc;
        pll_locked = 1'b1;
        wait_state(3, 30, "run_after_glitch");
        check("settle_restart", 32'(cyc - e0), 32'(3 + SETTLE_CYC));

        // Randomised loads and lock dropouts against the model
        for (int k = 0; k < 400; k++) begin
            pll_locked = ($urandom_range(0, 99) >= 3);
            if ($urandom_range(0, 9) == 0) begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    set_ch(ch, $urandom_range(0, 7), $urandom_range(0, 8));
                div_load = 1'b1;
            end else begin
                div_load = 1'b0;
            end
            tick();
        end
        div_load = 1'b0;

        // Mid-operation reset with simultaneous div_load
        pll_locked = 1'b1;
        wait_state(3, 40, "run_before_reset");
        for (int ch = 0; ch < NUM_CH; ch++) set_ch(ch, 7, 2);
        rst = 1'b0;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        check("rst_state", 32'(state), 32'(0));
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_ce", 32'(ce_out), 32'(0));
`ifdef PLL_CE_LOCK_LOSS_CNT_EN
        check("rst_llc", 32'(lock_loss_cnt), 32'(0));
`endif
        tick();
        rst = 1'b1;
        wait_state(3, 40, "run_after_reset");
        check("post_rst_div1_a", 32'(ce_out), 32'(4'hF));
        repeat (3) tick();
        check("post_rst_div1_b", 32'(ce_out), 32'(4'hF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
